// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, Hamming(7,4) bit positions and defaults
// shared by the UART receive controller and its decoder.
package uart_pkg;

  localparam logic [0:0] LOW_WAIT  = 1'b0;
  localparam logic [0:0] HIGH_WAIT = 1'b1;

  // Codeword bit k carries Hamming position k+1.
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D1 = 2;
  localparam int P4 = 3;
  localparam int D2 = 4;
  localparam int D3 = 5;
  localparam int D4 = 6;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/hamming74_decode.sv
// hamming74_decode: combinational single-error-correcting Hamming(7,4)
// decoder returning the corrected data nibble.
module hamming74_decode
  import uart_pkg::*;
(
  input  logic [6:0] codeword,
  output logic [3:0] nibble,
  output logic       corrected
);

  logic [2:0] syn;

  assign syn[0] = codeword[P1] ^ codeword[D1]
                ^ codeword[D2] ^ codeword[D4];
  assign syn[1] = codeword[P2] ^ codeword[D1]
                ^ codeword[D3] ^ codeword[D4];
  assign syn[2] = codeword[P4] ^ codeword[D2]
                ^ codeword[D3] ^ codeword[D4];

  // Syndrome names the faulty position; only data bits matter here.
  assign nibble = {
    codeword[D4] ^ (syn == 3'(D4 + 1)),
    codeword[D3] ^ (syn == 3'(D3 + 1)),
    codeword[D2] ^ (syn == 3'(D2 + 1)),
    codeword[D1] ^ (syn == 3'(D1 + 1))
  };

  assign corrected = |syn;

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: sample-tick generator, nibble pairing FSM with
// timeout, and byte FIFO behind a Hamming(7,4) receiver.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEF
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] baud_div,
  output logic       rx_ena,
  input  logic [6:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       err_corrected,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] TO_C = 8'(TIMEOUT);

  logic [7:0]    tick_cnt;
  logic          tick_d;
  logic [7:0]    to_cnt;
  logic [0:0]    state;
  logic [3:0]    low_nib;
  logic [3:0]    nib;
  logic          corr;
  logic          accept;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          timeout;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  hamming74_decode u_dec (
    .codeword  (rx_data),
    .nibble    (nib),
    .corrected (corr)
  );

  assign rx_ena     = rst_n & ena & (tick_cnt == baud_div);
  assign accept     = ena & tick_d & rx_valid;
  assign full       = (count == FULL_C);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid & byte_ready;
  assign push       = accept & (state == HIGH_WAIT);
  assign push_ok    = push & (~full | pop);
  assign byte_data  = byte_valid ? mem[rptr] : 8'h00;

  // An acceptance on the expiry cycle still completes the pair.
  assign timeout = ena & (state == HIGH_WAIT)
                 & (to_cnt == TO_C) & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 8'h00;
      tick_d   <= 1'b0;
    end else begin
      tick_d <= rx_ena;
      if (ena)
        tick_cnt <= (tick_cnt >= baud_div) ? 8'h00
                                            : tick_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOW_WAIT;
      low_nib       <= 4'h0;
      to_cnt        <= 8'h00;
      err_corrected <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      err_corrected <= accept & corr;
      frame_err     <= timeout;
      unique case (state)
        LOW_WAIT: begin
          if (accept) begin
            low_nib <= nib;
            to_cnt  <= 8'h00;
            state   <= HIGH_WAIT;
          end
        end
        HIGH_WAIT: begin
          if (accept || timeout)
            state <= LOW_WAIT;
          else if (rx_ena && to_cnt != TO_C)
            to_cnt <= to_cnt + 8'h01;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr] <= {nib, low_nib};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~pop;
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      count <= count + (AW + 1)'(push_ok)
                     - (AW + 1)'(pop);
    end
  end

endmodule
